alu_issue_arbiter: RTL and testbench

//  Shares one 32-bit integer ALU (ops AND..SRA, 4-bit CONTROL) between the two issue slots of the superscalar core.

---
 rtl/alu_issue_arbiter_if.sv | 52 +++++
 rtl/alu_issue_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter_if
//   Handshake bundle between the two issue slots, the shared-ALU arbiter and
//   writeback. The arbiter owns the slave side. The issue/RS logic and the
//   writeback consumer together form the master side.
//
//   req0_* / req1_* : per-slot valid/ready op request (op, a, b, tag)
//   res_*           : registered result toward writeback/CDB with valid/ready
// -----------------------------------------------------------------------------
interface alu_issue_arbiter_if #(
   parameter int TAG_W = 6
);
   logic             req0_valid;
   logic             req0_ready;
   logic [3:0]       req0_op;
   logic [31:0]      req0_a;
   logic [31:0]      req0_b;
   logic [TAG_W-1:0] req0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [3:0]       req1_op;
   logic [31:0]      req1_a;
   logic [31:0]      req1_b;
   logic [TAG_W-1:0] req1_tag;

   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic             res_zero;
   logic [TAG_W-1:0] res_tag;
   logic             res_src;
   logic             res_illegal;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req0_tag,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b, req1_tag,
      input  req1_ready,
      input  res_valid, res_data, res_zero, res_tag, res_src, res_illegal,
      output res_ready
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
      output req1_ready,
      output res_valid, res_data, res_zero, res_tag, res_src, res_illegal,
      input  res_ready
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//   Shares one 32-bit integer ALU between two issue slots. A round-robin
//   arbiter grants at most one slot per cycle. The granted op is evaluated
//   combinationally and captured in a single result register toward
//   writeback. Throughput is one op per cycle when writeback keeps up.
//
// Ports
//   clk          : clock, all state on the rising edge
//   reset        : asynchronous active-high reset
//   flush        : kills the held result and blocks grants this cycle
//   bus          : slave side of alu_issue_arbiter_if (requests + result)
//   conflict_cnt : saturating count of cycles in which both slots were valid
//                  and one was refused
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
   parameter int TAG_W  = 6,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   alu_issue_arbiter_if.slave bus,
   output logic [STAT_W-1:0] conflict_cnt
);

   // ALU control codes
   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_MOV = 4'd5;
   localparam logic [3:0] OP_LUI = 4'd6;
   localparam logic [3:0] OP_SLL = 4'd7;
   localparam logic [3:0] OP_SRL = 4'd8;
   localparam logic [3:0] OP_SRA = 4'd9;

   function automatic logic op_illegal(input logic [3:0] op);
      return (op > OP_SRA);
   endfunction

   // Illegal codes fall to the default arm and yield 0, never X.
   function automatic logic [31:0] alu_eval(input logic [3:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [31:0] a_s;
      logic [31:0]        r;
      a_s = a;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_XOR:  r = a ^ b;
         OP_MOV:  r = b;
         OP_LUI:  r = {b[15:0], 16'h0000};
         OP_SLL:  r = a << b[4:0];
         OP_SRL:  r = a >> b[4:0];
         OP_SRA:  r = $unsigned(a_s >>> b[4:0]);
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   logic              res_valid_q,   res_valid_d;
   logic [31:0]       res_data_q,    res_data_d;
   logic              res_zero_q,    res_zero_d;
   logic [TAG_W-1:0]  res_tag_q,     res_tag_d;
   logic              res_src_q,     res_src_d;
   logic              res_illegal_q, res_illegal_d;
   logic              rr_ptr_q,      rr_ptr_d;
   logic [STAT_W-1:0] conflict_cnt_q, conflict_cnt_d;

   logic              can_accept;
   logic              gnt0;
   logic              gnt1;
   logic              any_gnt;
   logic [3:0]        sel_op;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;
   logic [TAG_W-1:0]  sel_tag;
   logic [31:0]       alu_res;

   // Stage 0: arbitration and ALU evaluation
   always_comb begin
      can_accept = !flush && (!res_valid_q || bus.res_ready);

      // When both are valid the pointer decides; a lone requester always wins.
      gnt0    = can_accept && bus.req0_valid && (!bus.req1_valid || !rr_ptr_q);
      gnt1    = can_accept && bus.req1_valid && (!bus.req0_valid ||  rr_ptr_q);
      any_gnt = gnt0 || gnt1;

      sel_op  = gnt1 ? bus.req1_op  : bus.req0_op;
      sel_a   = gnt1 ? bus.req1_a   : bus.req0_a;
      sel_b   = gnt1 ? bus.req1_b   : bus.req0_b;
      sel_tag = gnt1 ? bus.req1_tag : bus.req0_tag;
      alu_res = alu_eval(sel_op, sel_a, sel_b);

      res_valid_d    = res_valid_q;
      res_data_d     = res_data_q;
      res_zero_d     = res_zero_q;
      res_tag_d      = res_tag_q;
      res_src_d      = res_src_q;
      res_illegal_d  = res_illegal_q;
      rr_ptr_d       = rr_ptr_q;
      conflict_cnt_d = conflict_cnt_q;

      if (flush) begin
         res_valid_d = 1'b0;
      end else if (any_gnt) begin
         // Covers both EMPTY load and FULL consume-and-reload.
         res_valid_d   = 1'b1;
         res_data_d    = alu_res;
         res_zero_d    = (alu_res == 32'h0000_0000);
         res_tag_d     = sel_tag;
         res_src_d     = gnt1;
         res_illegal_d = op_illegal(sel_op);
         rr_ptr_d      = ~gnt1;
      end else if (bus.res_ready) begin
         res_valid_d = 1'b0;
      end

      // can_accept already excludes flush; backpressure stalls are not conflicts.
      if (bus.req0_valid && bus.req1_valid && can_accept &&
          (conflict_cnt_q != {STAT_W{1'b1}})) begin
         conflict_cnt_d = conflict_cnt_q + 1'b1;
      end
   end

   // Stage 1: result register toward writeback
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
         res_zero_q     <= 1'b0;
         res_tag_q      <= '0;
         res_src_q      <= 1'b0;
         res_illegal_q  <= 1'b0;
         rr_ptr_q       <= 1'b0;
         conflict_cnt_q <= '0;
      end else begin
         res_valid_q    <= res_valid_d;
         res_data_q     <= res_data_d;
         res_zero_q     <= res_zero_d;
         res_tag_q      <= res_tag_d;
         res_src_q      <= res_src_d;
         res_illegal_q  <= res_illegal_d;
         rr_ptr_q       <= rr_ptr_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign bus.req0_ready  = gnt0;
   assign bus.req1_ready  = gnt1;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign bus.res_zero    = res_zero_q;
   assign bus.res_tag     = res_tag_q;
   assign bus.res_src     = res_src_q;
   assign bus.res_illegal = res_illegal_q;
   assign conflict_cnt    = conflict_cnt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
//   Directed bench for alu_issue_arbiter: a table of single-slot ALU ops with
//   hand-computed results, followed by hand-written sequences for round-robin
//   alternation, backpressure hold, flush, async reset and counter saturation.
//   The conflict counter is built 4 bits wide so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;
   localparam int TAG_W  = 6;
   localparam int STAT_W = 4;

   logic              clk;
   logic              reset;
   logic              flush;
   logic [STAT_W-1:0] conflict_cnt;

   int n_total;
   int n_pass;

   alu_issue_arbiter_if #(.TAG_W(TAG_W)) bif ();

   alu_issue_arbiter #(.TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .bus          (bif.slave),
      .conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             zero;
      logic             ill;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;

      vecs[0]  = '{4'd2, 32'd5,         32'd7,         6'd3,  32'd12,        1'b0, 1'b0};
      vecs[1]  = '{4'd3, 32'h1234,      32'h1234,      6'd4,  32'h0,         1'b1, 1'b0};
      vecs[2]  = '{4'd9, 32'h80000000,  32'd4,         6'd5,  32'hF8000000,  1'b0, 1'b0};
      vecs[3]  = '{4'd6, 32'h0,         32'hABCD,      6'd6,  32'hABCD0000,  1'b0, 1'b0};
      vecs[4]  = '{4'hF, 32'h1,         32'h1,         6'd7,  32'h0,         1'b1, 1'b1};
      vecs[5]  = '{4'd0, 32'hF0F0F0F0,  32'hFF00FF00,  6'd8,  32'hF000F000,  1'b0, 1'b0};
      vecs[6]  = '{4'd1, 32'h0F0F0000,  32'h000000F0,  6'd9,  32'h0F0F00F0,  1'b0, 1'b0};
      vecs[7]  = '{4'd4, 32'hFFFF0000,  32'hFFFFFFFF,  6'd10, 32'h0000FFFF,  1'b0, 1'b0};
      vecs[8]  = '{4'd5, 32'h12345678,  32'hDEADBEEF,  6'd11, 32'hDEADBEEF,  1'b0, 1'b0};
      vecs[9]  = '{4'd7, 32'h1,         32'd31,        6'd12, 32'h80000000,  1'b0, 1'b0};
      vecs[10] = '{4'd8, 32'h80000000,  32'd31,        6'd13, 32'h1,         1'b0, 1'b0};
      vecs[11] = '{4'd2, 32'hFFFFFFFF,  32'h1,         6'd14, 32'h0,         1'b1, 1'b0};
      vecs[12] = '{4'd3, 32'h0,         32'h1,         6'd15, 32'hFFFFFFFF,  1'b0, 1'b0};
      vecs[13] = '{4'hA, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd16, 32'h0,         1'b1, 1'b1};
      vecs[14] = '{4'd9, 32'h7FFFFFFF,  32'h24,        6'd17, 32'h07FFFFFF,  1'b0, 1'b0};

      flush          = 1'b0;
      bif.req0_valid = 1'b0; bif.req0_op = '0; bif.req0_a = '0; bif.req0_b = '0; bif.req0_tag = '0;
      bif.req1_valid = 1'b0; bif.req1_op = '0; bif.req1_a = '0; bif.req1_b = '0; bif.req1_tag = '0;
      bif.res_ready  = 1'b1;
      do_reset();

      check("reset_valid",    32'(bif.res_valid),   32'd0);
      check("reset_data",     bif.res_data,         32'd0);
      check("reset_zero",     32'(bif.res_zero),    32'd0);
      check("reset_tag",      32'(bif.res_tag),     32'd0);
      check("reset_src",      32'(bif.res_src),     32'd0);
      check("reset_illegal",  32'(bif.res_illegal), 32'd0);
      check("reset_conflict", 32'(conflict_cnt),    32'd0);

      // Table: slot 0 only, writeback always ready, back-to-back issue.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         bif.req0_valid = 1'b1;
         bif.req0_op    = vecs[i].op;
         bif.req0_a     = vecs[i].a;
         bif.req0_b     = vecs[i].b;
         bif.req0_tag   = vecs[i].tag;
         #1;
         check($sformatf("vec%0d_ready0", i), 32'(bif.req0_ready), 32'd1);
         @(posedge clk);
         #1;
         bif.req0_valid = 1'b0;
         check($sformatf("vec%0d_valid", i),   32'(bif.res_valid),   32'd1);
         check($sformatf("vec%0d_data", i),    bif.res_data,         vecs[i].data);
         check($sformatf("vec%0d_zero", i),    32'(bif.res_zero),    32'(vecs[i].zero));
         check($sformatf("vec%0d_illegal", i), 32'(bif.res_illegal), 32'(vecs[i].ill));
         check($sformatf("vec%0d_tag", i),     32'(bif.res_tag),     32'(vecs[i].tag));
         check($sformatf("vec%0d_src", i),     32'(bif.res_src),     32'd0);
      end
      check("table_conflict", 32'(conflict_cnt), 32'd0);
      @(posedge clk);
      #1;
      check("drain_valid", 32'(bif.res_valid), 32'd0);

      // Round robin: both slots valid every cycle from a fresh reset.
      do_reset();
      bif.req0_valid = 1'b1; bif.req0_op = 4'd2; bif.req0_a = 32'd1;  bif.req0_b = 32'd2;  bif.req0_tag = 6'd10;
      bif.req1_valid = 1'b1; bif.req1_op = 4'd2; bif.req1_a = 32'd10; bif.req1_b = 32'd20; bif.req1_tag = 6'd20;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("rr%0d_ready0", k), 32'(bif.req0_ready), 32'((k % 2) == 0));
         check($sformatf("rr%0d_ready1", k), 32'(bif.req1_ready), 32'((k % 2) == 1));
         @(posedge clk);
         #1;
         check($sformatf("rr%0d_src", k),      32'(bif.res_src),  32'(k % 2));
         check($sformatf("rr%0d_data", k),     bif.res_data,      ((k % 2) == 0) ? 32'd3 : 32'd30);
         check($sformatf("rr%0d_conflict", k), 32'(conflict_cnt), 32'(k + 1));
      end

      // Backpressure: FULL with slot-1 result, writeback stalls 5 cycles.
      @(negedge clk);
      bif.res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("hold%0d_ready0", k), 32'(bif.req0_ready), 32'd0);
         check($sformatf("hold%0d_ready1", k), 32'(bif.req1_ready), 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("hold%0d_valid", k),    32'(bif.res_valid), 32'd1);
         check($sformatf("hold%0d_data", k),     bif.res_data,       32'd30);
         check($sformatf("hold%0d_tag", k),      32'(bif.res_tag),   32'd20);
         check($sformatf("hold%0d_src", k),      32'(bif.res_src),   32'd1);
         check($sformatf("hold%0d_conflict", k), 32'(conflict_cnt),  32'd4);
         @(negedge clk);
      end
      bif.res_ready = 1'b1;
      #1;
      check("release_ready0", 32'(bif.req0_ready), 32'd1);
      check("release_ready1", 32'(bif.req1_ready), 32'd0);
      @(posedge clk);
      #1;
      check("release_src",      32'(bif.res_src),  32'd0);
      check("release_data",     bif.res_data,      32'd3);
      check("release_conflict", 32'(conflict_cnt), 32'd5);

      // Flush while FULL with both valid: no grant, pointer stays on slot 1.
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_ready0", 32'(bif.req0_ready), 32'd0);
      check("flush_ready1", 32'(bif.req1_ready), 32'd0);
      @(posedge clk);
      #1;
      check("flush_valid",    32'(bif.res_valid), 32'd0);
      check("flush_conflict", 32'(conflict_cnt),  32'd5);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("postflush_ready0", 32'(bif.req0_ready), 32'd0);
      check("postflush_ready1", 32'(bif.req1_ready), 32'd1);
      @(posedge clk);
      #1;
      check("postflush_src",      32'(bif.res_src),  32'd1);
      check("postflush_valid",    32'(bif.res_valid), 32'd1);
      check("postflush_conflict", 32'(conflict_cnt), 32'd6);

      // Asynchronous reset between edges clears everything immediately.
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("areset_valid",    32'(bif.res_valid), 32'd0);
      check("areset_data",     bif.res_data,       32'd0);
      check("areset_tag",      32'(bif.res_tag),   32'd0);
      check("areset_src",      32'(bif.res_src),   32'd0);
      check("areset_conflict", 32'(conflict_cnt),  32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Saturation: both valid for 20 cycles, 4-bit counter pins at 15.
      repeat (20) @(posedge clk);
      #1;
      check("sat_conflict", 32'(conflict_cnt), 32'd15);

      bif.req0_valid = 1'b0;
      bif.req1_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
